fp32_op_driver: RTL and testbench

Initiator-side sequencer for the team's two-operand stb/ack floating-point units (divider, and any unit with the same a/b/z port set). It accepts operand pairs from a host valid/ready stream and presents `a` then `b` to the unit with strobe/acknowledge handshakes. It then acknowledges the unit's `z` result and queues it in a small result FIFO for the host. It sits between a host datapath or testbench stimulus stream and one arithmetic unit, with exactly one operation in flight at a time.

---
 rtl/fp32_op_driver.sv | 161 ++++++++++++++++
 tb/tb_fp32_op_driver.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_op_driver.sv
// fp32_op_driver: issues host operand pairs to a two-operand stb/ack FP unit
// and queues the unit's results in a small FIFO, one operation in flight.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   in_a/in_b         host operand pair, in_valid/in_ready handshake
//   out_z             FIFO head result, out_valid/out_ready handshake
//   unit_a/unit_b     operands to the unit, each with a stb/ack pair
//   unit_z            unit result, unit_z_stb/unit_z_ack handshake
//   busy              an operation is in progress
//   err_timeout       sticky: unit stalled for TIMEOUT cycles
//   done_count        completed results, wraps at 16 bits
module fp32_op_driver #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_z,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] unit_a,
   output logic        unit_a_stb,
   input  logic        unit_a_ack,
   output logic [31:0] unit_b,
   output logic        unit_b_stb,
   input  logic        unit_b_ack,
   input  logic [31:0] unit_z,
   input  logic        unit_z_stb,
   output logic        unit_z_ack,
   output logic        busy,
   output logic        err_timeout,
   output logic [15:0] done_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEP = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);
   localparam logic [15:0] TMO = 16'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, WAIT_Z} state_t;

   state_t state, state_nx;

   logic          a_stb_nx, b_stb_nx, z_ack_nx;
   logic          load, push, pop;
   logic          a_xfer, b_xfer, z_xfer;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_nx;
   logic [31:0]   mem [DEPTH];
   logic [15:0]   tmo;

   assign a_xfer = unit_a_stb & unit_a_ack;
   assign b_xfer = unit_b_stb & unit_b_ack;
   assign z_xfer = unit_z_stb & unit_z_ack;
   assign pop    = out_valid & out_ready;
   assign out_z  = mem[rd_ptr];

   always_comb begin
      state_nx = state;
      a_stb_nx = unit_a_stb;
      b_stb_nx = unit_b_stb;
      z_ack_nx = unit_z_ack;
      load     = 1'b0;
      push     = 1'b0;
      unique case (state)
         IDLE: if (in_valid && in_ready) begin
            load     = 1'b1;
            a_stb_nx = 1'b1;
            state_nx = SEND_A;
         end
         SEND_A: if (a_xfer) begin
            a_stb_nx = 1'b0;
            b_stb_nx = 1'b1;
            state_nx = SEND_B;
         end
         SEND_B: if (b_xfer) begin
            b_stb_nx = 1'b0;
            z_ack_nx = 1'b1;
            state_nx = WAIT_Z;
         end
         WAIT_Z: if (z_xfer) begin
            push     = 1'b1;
            z_ack_nx = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

   always_comb begin
      count_nx = count;
      unique case ({push, pop})
         2'b10:   count_nx = count + ONE;
         2'b01:   count_nx = count - ONE;
         default: count_nx = count;
      endcase
   end

   // Status outputs are computed from next-state values so they are
   // registered yet still current in the cycle after each edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         unit_a_stb <= 1'b0;
         unit_b_stb <= 1'b0;
         unit_z_ack <= 1'b0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         done_count <= '0;
      end else begin
         state      <= state_nx;
         unit_a_stb <= a_stb_nx;
         unit_b_stb <= b_stb_nx;
         unit_z_ack <= z_ack_nx;
         in_ready   <= (state_nx == IDLE) && (count_nx < DEP);
         out_valid  <= (count_nx != '0);
         busy       <= (state_nx != IDLE);
         count      <= count_nx;
         if (push) begin
            wr_ptr     <= wr_ptr + 1'b1;
            done_count <= done_count + 16'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (load) begin
         unit_a <= in_a;
         unit_b <= in_b;
      end
      if (push)
         mem[wr_ptr] <= unit_z;
   end

   // Flag sets on the edge the stall counter would reach TIMEOUT;
   // the counter saturates so it never wraps back below it.
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo         <= '0;
         err_timeout <= 1'b0;
      end else if (state == IDLE || a_xfer || b_xfer || z_xfer) begin
         tmo <= '0;
      end else begin
         if (tmo != TMO)
            tmo <= tmo + 16'd1;
         if (tmo >= TMO - 16'd1)
            err_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fp32_op_driver.sv
// Testbench for fp32_op_driver: behavioural unit responder, result
// scoreboard, vector table, directed corner sequences and random traffic.
module tb_fp32_op_driver;

   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_a = '0, in_b = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] out_z;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] unit_a, unit_b;
   logic        unit_a_stb, unit_b_stb;
   logic        unit_a_ack = 1'b0, unit_b_ack = 1'b0;
   logic [31:0] unit_z = '0;
   logic        unit_z_stb = 1'b0;
   logic        unit_z_ack;
   logic        busy, err_timeout;
   logic [15:0] done_count;

   always #5 clock = ~clock;

   fp32_op_driver #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset),
      .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
      .out_z(out_z), .out_valid(out_valid), .out_ready(out_ready),
      .unit_a(unit_a), .unit_a_stb(unit_a_stb), .unit_a_ack(unit_a_ack),
      .unit_b(unit_b), .unit_b_stb(unit_b_stb), .unit_b_ack(unit_b_ack),
      .unit_z(unit_z), .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack),
      .busy(busy), .err_timeout(err_timeout), .done_count(done_count)
   );

   int total = 0;
   int bad   = 0;
   int ops   = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chk(nm, 32'(act), 32'(exp));
   endtask

   task automatic flunk(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got timeout want event", nm);
   endtask

   // Model of the attached unit's arithmetic (chosen so 6.0, 2.0 -> 3.0).
   function automatic logic [31:0] unit_fn(input logic [31:0] a,
                                           input logic [31:0] b);
      return a ^ b ^ 32'h4080_0000;
   endfunction

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   // Unit responder: drives acks/results at each negedge.
   int          a_wait = 0, b_wait = 0, z_lat = 0;
   bit          z_never = 0;
   int          a_cnt = 0, b_cnt = 0, z_cnt = 0;
   logic [31:0] cap_a = '0, cap_b = '0;

   initial begin
      forever begin
         @(negedge clock);
         if (reset) begin
            a_cnt = 0; b_cnt = 0; z_cnt = 0;
            unit_a_ack = 1'b0; unit_b_ack = 1'b0; unit_z_stb = 1'b0;
         end else begin
            if (unit_a_stb) begin
               unit_a_ack = (a_cnt >= a_wait); a_cnt++;
            end else begin
               a_cnt = 0; unit_a_ack = (a_wait == 0);
            end
            if (unit_a_stb && unit_a_ack) cap_a = unit_a;
            if (unit_b_stb) begin
               unit_b_ack = (b_cnt >= b_wait); b_cnt++;
            end else begin
               b_cnt = 0; unit_b_ack = (b_wait == 0);
            end
            if (unit_b_stb && unit_b_ack) cap_b = unit_b;
            if (unit_z_ack) begin
               if (!z_never && z_cnt >= z_lat) begin
                  unit_z_stb = 1'b1;
                  unit_z = unit_fn(cap_a, cap_b);
               end
               z_cnt++;
            end else begin
               z_cnt = 0; unit_z_stb = 1'b0;
            end
         end
      end
   end

   // Host sink: drives out_ready and checks every pop against the model.
   int          rdy_mode = 0;
   logic [31:0] exp_q[$];

   initial begin
      forever begin
         @(negedge clock);
         #2;
         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL pop_unexpected: got %h want none", out_z);
            end else begin
               chk("pop_order", out_z, exp_q.pop_front());
            end
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      in_a = a; in_b = b; in_valid = 1'b1;
      while (!in_ready && n < 300) begin step(); n++; end
      if (in_ready) begin
         exp_q.push_back(unit_fn(a, b));
         ops++;
      end else begin
         flunk("issue_accept");
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      while (!out_valid && n < 100) begin step(); n++; end
      if (!out_valid) flunk(nm);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 100) begin step(); n++; end
      if (busy) flunk(nm);
   endtask

   task automatic pop_one();
      rdy_mode = 1;
      step();
      rdy_mode = 0;
   endtask

   typedef struct {
      logic [31:0] a, b;
      int          aw, bw, zl;
      logic [31:0] z;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int n;
      int seen;
      tbl[0] = '{32'h40C0_0000, 32'h4000_0000, 0, 0, 0, 32'h4040_0000};
      tbl[1] = '{32'h3F80_0000, 32'h3F80_0000, 1, 2, 3, 32'h4080_0000};
      tbl[2] = '{32'h0000_0000, 32'h0000_0000, 3, 0, 1, 32'h4080_0000};
      tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 0, 4, 0, 32'hBF7F_FFFF};
      tbl[4] = '{32'h1234_5678, 32'h4080_0000, 2, 2, 6, 32'h1234_5678};
      tbl[5] = '{32'h7F80_0000, 32'hFF80_0000, 5, 1, 2, 32'hC080_0000};

      repeat (3) step();
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_a_stb", unit_a_stb, 1'b0);
      chk1("rst_b_stb", unit_b_stb, 1'b0);
      chk1("rst_z_ack", unit_z_ack, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err_timeout, 1'b0);
      chk("rst_done", 32'(done_count), 32'd0);
      reset = 1'b0;
      step();
      chk1("post_rst_in_ready", in_ready, 1'b1);

      // zero-wait operation, cycle by cycle
      issue(32'h40C0_0000, 32'h4000_0000);
      chk1("c1_a_stb", unit_a_stb, 1'b1);
      chk("c1_unit_a", unit_a, 32'h40C0_0000);
      chk1("c1_b_stb", unit_b_stb, 1'b0);
      step();
      chk1("c2_a_stb", unit_a_stb, 1'b0);
      chk1("c2_b_stb", unit_b_stb, 1'b1);
      chk("c2_unit_b", unit_b, 32'h4000_0000);
      step();
      chk1("c3_z_ack", unit_z_ack, 1'b1);
      chk1("c3_b_stb", unit_b_stb, 1'b0);
      step();
      chk1("c4_out_valid", out_valid, 1'b1);
      chk("c4_out_z", out_z, 32'h4040_0000);
      chk("c4_done", 32'(done_count), 32'd1);
      chk1("c4_in_ready", in_ready, 1'b1);
      pop_one();
      chk1("c5_out_valid", out_valid, 1'b0);

      // a-side stall of 10 cycles
      a_wait = 10;
      issue(32'h3F80_0000, 32'h4040_0000);
      for (int i = 0; i < 10; i++) begin
         chk1("stall_a_stb", unit_a_stb, 1'b1);
         chk("stall_unit_a", unit_a, 32'h3F80_0000);
         chk1("stall_b_stb", unit_b_stb, 1'b0);
         step();
      end
      a_wait = 0;
      wait_valid("stall_result");
      chk("stall_out_z", out_z, 32'h4080_0000 ^ 32'h3F80_0000 ^ 32'h4040_0000);
      pop_one();

      // vector table
      foreach (tbl[i]) begin
         a_wait = tbl[i].aw; b_wait = tbl[i].bw; z_lat = tbl[i].zl;
         issue(tbl[i].a, tbl[i].b);
         wait_valid("tbl_result");
         chk("tbl_out_z", out_z, tbl[i].z);
         chk("tbl_done", 32'(done_count), 32'(ops));
         pop_one();
      end
      a_wait = 0; b_wait = 0; z_lat = 0;

      // fill the FIFO, then hold a further pair until a pop
      for (int i = 0; i < DEPTH; i++)
         issue(32'h3F80_0000, 32'h3F80_0000 + 32'(i));
      in_a = 32'h3F80_0000; in_b = 32'h3F80_0000 + 32'(DEPTH);
      in_valid = 1'b1;
      wait_idle("full_idle");
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (in_ready) seen++;
         step();
      end
      chk("full_in_ready_cycles", 32'(seen), 32'd0);
      chk1("full_out_valid", out_valid, 1'b1);
      chk1("full_busy", busy, 1'b0);
      pop_one();
      issue(32'h3F80_0000, 32'h3F80_0000 + 32'(DEPTH));
      rdy_mode = 1;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin step(); n++; end
      rdy_mode = 0;
      chk("full_drain_left", 32'(exp_q.size()), 32'd0);

      // push and pop on the same edge with two entries queued
      issue(32'h4000_0000, 32'h0000_0001);
      issue(32'h4000_0000, 32'h0000_0002);
      wait_idle("pp_idle");
      z_lat = 3;
      issue(32'h4000_0000, 32'h0000_0003);
      n = 0;
      while (!(unit_z_stb && unit_z_ack) && n < 50) begin step(); n++; end
      if (!(unit_z_stb && unit_z_ack)) flunk("pp_z_stb");
      pop_one();
      z_lat = 0;
      chk1("pp_out_valid", out_valid, 1'b1);
      chk("pp_head", out_z, unit_fn(32'h4000_0000, 32'h0000_0002));
      pop_one();
      chk1("pp_one_left", out_valid, 1'b1);
      pop_one();
      chk1("pp_empty", out_valid, 1'b0);

      // random traffic against the scoreboard
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         a_wait = $urandom_range(0, 3);
         b_wait = $urandom_range(0, 3);
         z_lat  = $urandom_range(0, 5);
         issue($urandom, $urandom);
         repeat ($urandom_range(0, 2)) step();
      end
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin step(); n++; end
      rdy_mode = 0;
      a_wait = 0; b_wait = 0; z_lat = 0;
      chk("rand_drain_left", 32'(exp_q.size()), 32'd0);
      chk("rand_done", 32'(done_count), 32'(ops[15:0]));
      chk1("rand_no_err", err_timeout, 1'b0);

      // unit withholds z: timeout after 16 stalled cycles
      z_never = 1;
      issue(32'h40C0_0000, 32'h4000_0000);
      n = 0;
      while (!(unit_b_stb && unit_b_ack) && n < 50) begin step(); n++; end
      if (!(unit_b_stb && unit_b_ack)) flunk("tmo_b_xfer");
      step();
      for (int k = 1; k <= 16; k++) begin
         step();
         if (k == 15) chk1("tmo_not_yet", err_timeout, 1'b0);
         if (k == 16) chk1("tmo_set", err_timeout, 1'b1);
      end
      repeat (20) step();
      z_never = 0;
      wait_valid("tmo_late_z");
      chk("tmo_out_z", out_z, 32'h4040_0000);
      chk1("tmo_sticky", err_timeout, 1'b1);
      chk1("tmo_idle", busy, 1'b0);

      // reset while in SEND_B with two results queued
      issue(32'h3F80_0000, 32'h3F80_0000);
      wait_idle("rst2_idle");
      b_wait = 20;
      issue(32'h4000_0000, 32'h4000_0000);
      n = 0;
      while (!unit_b_stb && n < 20) begin step(); n++; end
      if (!unit_b_stb) flunk("rst2_send_b");
      reset = 1'b1;
      exp_q.delete();
      step();
      chk1("mid_rst_a_stb", unit_a_stb, 1'b0);
      chk1("mid_rst_b_stb", unit_b_stb, 1'b0);
      chk1("mid_rst_z_ack", unit_z_ack, 1'b0);
      chk1("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_done", 32'(done_count), 32'd0);
      chk1("mid_rst_err", err_timeout, 1'b0);
      chk1("mid_rst_busy", busy, 1'b0);
      reset = 1'b0;
      b_wait = 0;
      step();
      chk1("mid_rst_in_ready", in_ready, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
